// File: rtl/pma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pma_pkg
// Description : Shared types and helpers for the runtime-programmable PMA
//               checker: attribute/rule records, config field selector and
//               the address range test.
// Revision    : 1.0 - initial release
// ============================================================================
package pma_pkg;

  localparam int c_MAX_PMA_RULES = 32;

  // Bit positions inside a rule's 5-bit attribute field.
  localparam int c_ATTR_NONIDEM = 0;
  localparam int c_ATTR_CACHE   = 1;
  localparam int c_ATTR_EXEC    = 2;
  localparam int c_ATTR_EN      = 3;
  localparam int c_ATTR_LOCK    = 4;

  typedef struct packed {
    logic exec;
    logic cache;
    logic nonidem;
  } pma_attr_t;

  typedef struct packed {
    logic [63:0] base;
    logic [63:0] len;
    logic [4:0]  attr;
  } pma_rule_t;

  typedef enum logic [1:0] {
    PMA_SEL_BASE = 2'd0,
    PMA_SEL_LEN  = 2'd1,
    PMA_SEL_ATTR = 2'd2
  } pma_sel_e;

  // Half-open range test [base, base+len). The upper bound is formed one
  // bit wider than the address so a region ending at the top of the
  // address space does not wrap to zero.
  function automatic logic range_check(input logic [63:0] base,
                                       input logic [63:0] len,
                                       input logic [63:0] addr);
    logic [64:0] w_top;
    w_top = {1'b0, base} + {1'b0, len};
    return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < w_top);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pma_match.sv
`default_nettype none
// ============================================================================
// Module      : pma_match
// Description : Combinational priority matcher. Compares one address against
//               every rule; the lowest-indexed enabled, non-empty rule that
//               contains the address wins.
// Ports       : i_rules  - rule array (active table)
//               i_addr   - lookup address
//               o_hit    - some rule matched
//               o_idx    - winning rule index (0 on miss)
//               o_attr   - winning attributes (DEFAULT_ATTR on miss)
// Revision    : 1.0 - initial release
// ============================================================================
module pma_match
  import pma_pkg::*;
#(
  parameter int        NR_RULES     = 16,
  parameter int        ADDR_WIDTH   = 64,
  parameter pma_attr_t DEFAULT_ATTR = pma_attr_t'(3'b110),
  localparam int       IDX_W        = (NR_RULES > 1) ? $clog2(NR_RULES) : 1
) (
  input  pma_rule_t              i_rules [NR_RULES],
  input  logic [ADDR_WIDTH-1:0]  i_addr,
  output logic                   o_hit,
  output logic [IDX_W-1:0]       o_idx,
  output pma_attr_t              o_attr
);

  // Rule fields are stored 64 bits wide; only the implemented address bits
  // take part in the comparison.
  localparam logic [63:0] c_ADDR_MASK = {64{1'b1}} >> (64 - ADDR_WIDTH);

  logic [NR_RULES-1:0] w_match;
  logic [63:0]         w_addr;

  assign w_addr = 64'(i_addr);

  for (genvar i = 0; i < NR_RULES; i++) begin : g_rule
    logic [63:0] w_base;
    logic [63:0] w_len;
    assign w_base     = i_rules[i].base & c_ADDR_MASK;
    assign w_len      = i_rules[i].len & c_ADDR_MASK;
    assign w_match[i] = i_rules[i].attr[c_ATTR_EN] && (w_len != 64'd0) &&
                        range_check(w_base, w_len, w_addr);
  end

  // Scan from the top down so the lowest matching index is the last writer.
  always_comb begin
    o_hit  = 1'b0;
    o_idx  = '0;
    o_attr = DEFAULT_ATTR;
    for (int i = NR_RULES - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        o_hit  = 1'b1;
        o_idx  = IDX_W'(i);
        o_attr = pma_attr_t'(i_rules[i].attr[2:0]);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pma_region_unit.sv
`default_nettype none
// ============================================================================
// Module      : pma_region_unit
// Description : Runtime-programmable physical memory attribute checker.
//               Software writes rules into a shadow table and commits them
//               atomically into the active table. Each lookup port returns a
//               registered, priority-ordered attribute response one cycle
//               after acceptance, with valid/ready flow control.
// Ports       : clk_i, rst_i           - clock, synchronous active-high reset
//               cfg_req_i/idx/sel/wdata - shadow table field write
//               cfg_commit_i            - copy shadow table to active table
//               cfg_gnt_o / cfg_err_o   - 1-cycle write accept / reject pulse
//               lk_valid_i/ready_o/addr - per-port lookup request
//               rsp_valid_o/ready_i     - per-port response handshake
//               rsp_attr_o/hit_o/idx_o  - per-port lookup result
// Revision    : 1.0 - initial release
// ============================================================================
module pma_region_unit
  import pma_pkg::*;
#(
  parameter int        NR_RULES     = 16,
  parameter int        NR_PORTS     = 2,
  parameter int        ADDR_WIDTH   = 64,
  parameter pma_attr_t DEFAULT_ATTR = pma_attr_t'(3'b110),
  localparam int       IDX_W        = (NR_RULES > 1) ? $clog2(NR_RULES) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           cfg_req_i,
  input  logic [IDX_W-1:0]               cfg_idx_i,
  input  logic [1:0]                     cfg_sel_i,
  input  logic [63:0]                    cfg_wdata_i,
  input  logic                           cfg_commit_i,
  output logic                           cfg_gnt_o,
  output logic                           cfg_err_o,
  input  logic [NR_PORTS-1:0]            lk_valid_i,
  output logic [NR_PORTS-1:0]            lk_ready_o,
  input  logic [NR_PORTS*ADDR_WIDTH-1:0] lk_addr_i,
  output logic [NR_PORTS-1:0]            rsp_valid_o,
  input  logic [NR_PORTS-1:0]            rsp_ready_i,
  output logic [NR_PORTS*3-1:0]          rsp_attr_o,
  output logic [NR_PORTS-1:0]            rsp_hit_o,
  output logic [NR_PORTS*IDX_W-1:0]      rsp_idx_o
);

  pma_rule_t r_shadow [NR_RULES];
  pma_rule_t r_active [NR_RULES];
  logic      r_gnt;
  logic      r_err;

  logic      w_idx_valid;
  logic      w_idx_locked;
  logic      w_wr_ok;

  // Lock protection is decided from the ACTIVE copy, so a lock bit that has
  // only been staged in the shadow does not yet block further edits.
  always_comb begin
    w_idx_valid  = ({1'b0, cfg_idx_i} < (IDX_W + 1)'(NR_RULES));
    w_idx_locked = 1'b0;
    if (w_idx_valid) begin
      w_idx_locked = r_active[cfg_idx_i].attr[c_ATTR_LOCK];
    end
    w_wr_ok = w_idx_valid && !w_idx_locked;
  end

  // Commit copies the pre-edge shadow, so a write in the same cycle lands
  // in the shadow only and waits for the next commit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NR_RULES; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
      r_gnt <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (cfg_commit_i) begin
        r_active <= r_shadow;
      end
      r_gnt <= cfg_req_i && w_wr_ok;
      r_err <= cfg_req_i && !w_wr_ok;
      if (cfg_req_i && w_wr_ok) begin
        case (pma_sel_e'(cfg_sel_i))
          PMA_SEL_BASE: r_shadow[cfg_idx_i].base <= cfg_wdata_i;
          PMA_SEL_LEN:  r_shadow[cfg_idx_i].len  <= cfg_wdata_i;
          PMA_SEL_ATTR: r_shadow[cfg_idx_i].attr <= cfg_wdata_i[4:0];
          default:      ;
        endcase
      end
    end
  end

  assign cfg_gnt_o = r_gnt;
  assign cfg_err_o = r_err;

  for (genvar p = 0; p < NR_PORTS; p++) begin : g_port
    logic             w_hit;
    logic [IDX_W-1:0] w_idx;
    pma_attr_t        w_attr;
    logic             w_accept;
    logic             r_valid;
    logic             r_hit;
    logic [IDX_W-1:0] r_idx;
    pma_attr_t        r_attr;

    pma_match #(
      .NR_RULES     (NR_RULES),
      .ADDR_WIDTH   (ADDR_WIDTH),
      .DEFAULT_ATTR (DEFAULT_ATTR)
    ) u_match (
      .i_rules (r_active),
      .i_addr  (lk_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH]),
      .o_hit   (w_hit),
      .o_idx   (w_idx),
      .o_attr  (w_attr)
    );

    assign lk_ready_o[p] = !r_valid || rsp_ready_i[p];
    assign w_accept      = lk_valid_i[p] && lk_ready_o[p];

    // Result fields only load on acceptance, so they stay frozen while the
    // consumer is stalling.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_valid <= 1'b0;
        r_hit   <= 1'b0;
        r_idx   <= '0;
        r_attr  <= '0;
      end else if (w_accept) begin
        r_valid <= 1'b1;
        r_hit   <= w_hit;
        r_idx   <= w_idx;
        r_attr  <= w_attr;
      end else if (rsp_ready_i[p]) begin
        r_valid <= 1'b0;
      end
    end

    assign rsp_valid_o[p]              = r_valid;
    assign rsp_hit_o[p]                = r_hit;
    assign rsp_idx_o[p*IDX_W +: IDX_W] = r_idx;
    assign rsp_attr_o[p*3 +: 3]        = r_attr;
  end

endmodule
`default_nettype wire

// File: tb/tb_pma_region_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pma_region_unit
// Description : Self-checking bench for pma_region_unit with a response
//               scoreboard per lookup port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pma_region_unit;
  import pma_pkg::*;

  localparam int NR = 12;
  localparam int NP = 2;
  localparam int AW = 64;
  localparam int IW = 4;

  localparam logic [63:0] A_EN      = 64'h08;
  localparam logic [63:0] A_LOCK    = 64'h10;
  localparam logic [63:0] A_EXEC    = 64'h04;
  localparam logic [63:0] A_CACHE   = 64'h02;
  localparam logic [63:0] A_NONIDEM = 64'h01;

  typedef struct packed {
    logic          hit;
    logic [IW-1:0] idx;
    logic [2:0]    attr;
  } exp_t;

  logic               clk;
  logic               rst_i;
  logic               cfg_req_i;
  logic [IW-1:0]      cfg_idx_i;
  logic [1:0]         cfg_sel_i;
  logic [63:0]        cfg_wdata_i;
  logic               cfg_commit_i;
  logic               cfg_gnt_o;
  logic               cfg_err_o;
  logic [NP-1:0]      lk_valid_i;
  logic [NP-1:0]      lk_ready_o;
  logic [NP*AW-1:0]   lk_addr_i;
  logic [NP-1:0]      rsp_valid_o;
  logic [NP-1:0]      rsp_ready_i;
  logic [NP*3-1:0]    rsp_attr_o;
  logic [NP-1:0]      rsp_hit_o;
  logic [NP*IW-1:0]   rsp_idx_o;

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   mon_en   = 1'b0;
  bit   held_v [NP];
  exp_t held   [NP];
  int   n_rsp  [NP];

  pma_region_unit #(
    .NR_RULES     (NR),
    .NR_PORTS     (NP),
    .ADDR_WIDTH   (AW),
    .DEFAULT_ATTR (pma_attr_t'(3'b110))
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .cfg_req_i    (cfg_req_i),
    .cfg_idx_i    (cfg_idx_i),
    .cfg_sel_i    (cfg_sel_i),
    .cfg_wdata_i  (cfg_wdata_i),
    .cfg_commit_i (cfg_commit_i),
    .cfg_gnt_o    (cfg_gnt_o),
    .cfg_err_o    (cfg_err_o),
    .lk_valid_i   (lk_valid_i),
    .lk_ready_o   (lk_ready_o),
    .lk_addr_i    (lk_addr_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_attr_o   (rsp_attr_o),
    .rsp_hit_o    (rsp_hit_o),
    .rsp_idx_o    (rsp_idx_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic h, input int i, input logic [2:0] a);
    exp_t e;
    e.hit  = h;
    e.idx  = IW'(i);
    e.attr = a;
    return e;
  endfunction

  function automatic exp_t miss();
    return mk(1'b0, 0, 3'b110);
  endfunction

  function automatic exp_t obs(input int p);
    exp_t e;
    e.hit  = rsp_hit_o[p];
    e.idx  = rsp_idx_o[p*IW +: IW];
    e.attr = rsp_attr_o[p*3 +: 3];
    return e;
  endfunction

  task automatic push_exp(input int p, input exp_t e);
    if (p == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Response monitor: pops the scoreboard on every completed handshake and
  // checks that stalled responses do not change.
  always @(negedge clk) begin
    exp_t o;
    exp_t e;
    bit   have;
    if (mon_en) begin
      for (int p = 0; p < NP; p++) begin
        if (rsp_valid_o[p]) begin
          o = obs(p);
          if (held_v[p]) begin
            n_checks++;
            if (o !== held[p])
              $display("FAIL hold_port%0d: got %h required %h", p, o, held[p]);
            else
              n_pass++;
          end
          if (rsp_ready_i[p]) begin
            held_v[p] = 1'b0;
            n_rsp[p]++;
            have = 1'b0;
            if (p == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            if (p == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            n_checks++;
            if (!have)
              $display("FAIL rsp_port%0d: got unexpected response %h, required none", p, o);
            else if (o !== e)
              $display("FAIL rsp_port%0d: got {hit,idx,attr}=%h required %h", p, o, e);
            else
              n_pass++;
          end else begin
            held_v[p] = 1'b1;
            held[p]   = o;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    mon_en       = 1'b0;
    rst_i        = 1'b1;
    cfg_req_i    = 1'b0;
    cfg_idx_i    = '0;
    cfg_sel_i    = '0;
    cfg_wdata_i  = '0;
    cfg_commit_i = 1'b0;
    lk_valid_i   = '0;
    lk_addr_i    = '0;
    rsp_ready_i  = '1;
    tick();
    rst_i = 1'b0;
    q0.delete();
    q1.delete();
    for (int p = 0; p < NP; p++) held_v[p] = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) tick();
    n_checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      $display("FAIL drain: got %0d/%0d responses outstanding, required 0/0",
               q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end else begin
      n_pass++;
    end
  endtask

  task automatic do_lookup(input int p, input logic [63:0] a, input exp_t e);
    lk_valid_i[p]           = 1'b1;
    lk_addr_i[p*AW +: AW]   = a;
    push_exp(p, e);
    tick();
    lk_valid_i[p] = 1'b0;
    n_checks++;
    if (rsp_valid_o[p] !== 1'b1)
      $display("FAIL latency_port%0d addr %h: got rsp_valid=%b required 1", p, a, rsp_valid_o[p]);
    else
      n_pass++;
    drain();
  endtask

  task automatic cfg_write(input int idx, input pma_sel_e sel, input logic [63:0] d,
                           input logic exp_gnt);
    logic [1:0] req;
    cfg_req_i   = 1'b1;
    cfg_idx_i   = IW'(idx);
    cfg_sel_i   = sel;
    cfg_wdata_i = d;
    tick();
    cfg_req_i = 1'b0;
    req = exp_gnt ? 2'b10 : 2'b01;
    n_checks++;
    if ({cfg_gnt_o, cfg_err_o} !== req)
      $display("FAIL cfg_resp idx%0d sel%0d: got gnt,err=%b%b required %b",
               idx, sel, cfg_gnt_o, cfg_err_o, req);
    else
      n_pass++;
    tick();
    n_checks++;
    if ({cfg_gnt_o, cfg_err_o} !== 2'b00)
      $display("FAIL cfg_pulse idx%0d: got gnt,err=%b%b required 00", idx, cfg_gnt_o, cfg_err_o);
    else
      n_pass++;
  endtask

  task automatic commit();
    cfg_commit_i = 1'b1;
    tick();
    cfg_commit_i = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({rsp_valid_o, lk_ready_o, cfg_gnt_o, cfg_err_o} !== {2'b00, 2'b11, 2'b00})
      $display("FAIL reset_ctrl: got valid=%b ready=%b gnt=%b err=%b required 00 11 0 0",
               rsp_valid_o, lk_ready_o, cfg_gnt_o, cfg_err_o);
    else
      n_pass++;
    n_checks++;
    if ({rsp_attr_o, rsp_hit_o, rsp_idx_o} !== '0)
      $display("FAIL reset_data: got attr=%h hit=%b idx=%h required 0",
               rsp_attr_o, rsp_hit_o, rsp_idx_o);
    else
      n_pass++;
  endtask

  task automatic test_default_miss();
    do_lookup(0, 64'h8000_0000, miss());
    do_lookup(1, 64'h8000_0000, miss());
  endtask

  task automatic test_overlap();
    cfg_write(0, PMA_SEL_BASE, 64'h1000_0000, 1'b1);
    cfg_write(0, PMA_SEL_LEN,  64'h1000, 1'b1);
    cfg_write(0, PMA_SEL_ATTR, A_NONIDEM | A_EN, 1'b1);
    cfg_write(1, PMA_SEL_BASE, 64'h1000_0000, 1'b1);
    cfg_write(1, PMA_SEL_LEN,  64'h10_0000, 1'b1);
    cfg_write(1, PMA_SEL_ATTR, A_CACHE | A_EXEC | A_EN, 1'b1);
    commit();
    do_lookup(0, 64'h1000_0800, mk(1'b1, 0, 3'b001));
    do_lookup(1, 64'h1000_1000, mk(1'b1, 1, 3'b110));
    do_lookup(0, 64'h1010_0000, miss());
    do_lookup(1, 64'h0FFF_FFFF, miss());
    do_lookup(1, 64'h100F_FFFF, mk(1'b1, 1, 3'b110));
  endtask

  task automatic test_back_to_back();
    localparam int N = 10;
    logic [63:0] atab [4];
    exp_t        etab [4];
    int i0, i1, cyc;
    atab[0] = 64'h1000_0800; etab[0] = mk(1'b1, 0, 3'b001);
    atab[1] = 64'h1000_1000; etab[1] = mk(1'b1, 1, 3'b110);
    atab[2] = 64'h1010_0000; etab[2] = miss();
    atab[3] = 64'h1000_0000; etab[3] = mk(1'b1, 0, 3'b001);
    i0 = 0; i1 = 0; cyc = 0;
    for (int p = 0; p < NP; p++) n_rsp[p] = 0;
    while ((i0 < N || i1 < N) && cyc < 60) begin
      rsp_ready_i[0]       = !(cyc >= 2 && cyc < 7);
      rsp_ready_i[1]       = 1'b1;
      lk_valid_i[0]        = (i0 < N);
      lk_addr_i[0 +: AW]   = atab[i0 % 4];
      lk_valid_i[1]        = (i1 < N);
      lk_addr_i[AW +: AW]  = atab[(i1 + 1) % 4];
      @(negedge clk);
      if (cyc == 4) begin
        n_checks++;
        if (lk_ready_o[0] !== 1'b0)
          $display("FAIL stall_ready: got lk_ready[0]=%b required 0", lk_ready_o[0]);
        else
          n_pass++;
      end
      if (lk_valid_i[0] && lk_ready_o[0]) begin push_exp(0, etab[i0 % 4]); i0++; end
      if (lk_valid_i[1] && lk_ready_o[1]) begin push_exp(1, etab[(i1 + 1) % 4]); i1++; end
      if (cyc == N - 1) begin
        n_checks++;
        if (i1 != N)
          $display("FAIL port1_rate: got %0d accepted after %0d cycles, required %0d", i1, N, N);
        else
          n_pass++;
      end
      tick();
      cyc++;
    end
    lk_valid_i  = '0;
    rsp_ready_i = '1;
    n_checks++;
    if (i0 != N || i1 != N)
      $display("FAIL stream_accept: got %0d/%0d accepted required %0d/%0d", i0, i1, N, N);
    else
      n_pass++;
    drain();
    n_checks++;
    if (n_rsp[0] != N || n_rsp[1] != N)
      $display("FAIL stream_count: got %0d/%0d responses required %0d/%0d",
               n_rsp[0], n_rsp[1], N, N);
    else
      n_pass++;
  endtask

  task automatic test_top_range();
    cfg_write(4, PMA_SEL_BASE, 64'hFFFF_FFFF_FFFF_F000, 1'b1);
    cfg_write(4, PMA_SEL_LEN,  64'h1000, 1'b1);
    cfg_write(4, PMA_SEL_ATTR, A_EXEC | A_EN, 1'b1);
    cfg_write(5, PMA_SEL_BASE, 64'h2000_0000, 1'b1);
    cfg_write(5, PMA_SEL_LEN,  64'h0, 1'b1);
    cfg_write(5, PMA_SEL_ATTR, A_NONIDEM | A_EN, 1'b1);
    commit();
    do_lookup(0, 64'hFFFF_FFFF_FFFF_FFFF, mk(1'b1, 4, 3'b100));
    do_lookup(1, 64'hFFFF_FFFF_FFFF_F000, mk(1'b1, 4, 3'b100));
    do_lookup(0, 64'hFFFF_FFFF_FFFF_EFFF, miss());
    do_lookup(1, 64'h2000_0000, miss());
  endtask

  task automatic test_shadow_commit();
    cfg_write(2, PMA_SEL_BASE, 64'h3000_0000, 1'b1);
    cfg_write(2, PMA_SEL_LEN,  64'h1000, 1'b1);
    cfg_write(2, PMA_SEL_ATTR, A_EN | A_CACHE | A_NONIDEM, 1'b1);
    do_lookup(0, 64'h3000_0000, miss());
    // Commit and lookup together, then a lookup on the very next cycle.
    cfg_commit_i       = 1'b1;
    lk_valid_i[0]      = 1'b1;
    lk_addr_i[0 +: AW] = 64'h3000_0000;
    push_exp(0, miss());
    tick();
    cfg_commit_i = 1'b0;
    push_exp(0, mk(1'b1, 2, 3'b011));
    tick();
    lk_valid_i[0] = 1'b0;
    drain();
    // A write landing in the commit cycle waits for the next commit.
    cfg_req_i    = 1'b1;
    cfg_idx_i    = IW'(2);
    cfg_sel_i    = PMA_SEL_ATTR;
    cfg_wdata_i  = A_EN | A_EXEC;
    cfg_commit_i = 1'b1;
    tick();
    cfg_req_i    = 1'b0;
    cfg_commit_i = 1'b0;
    n_checks++;
    if ({cfg_gnt_o, cfg_err_o} !== 2'b10)
      $display("FAIL commit_write_gnt: got gnt,err=%b%b required 10", cfg_gnt_o, cfg_err_o);
    else
      n_pass++;
    do_lookup(1, 64'h3000_0010, mk(1'b1, 2, 3'b011));
    commit();
    do_lookup(1, 64'h3000_0010, mk(1'b1, 2, 3'b100));
  endtask

  task automatic test_lock();
    cfg_write(3, PMA_SEL_BASE, 64'h4000_0000, 1'b1);
    cfg_write(3, PMA_SEL_LEN,  64'h1000, 1'b1);
    cfg_write(3, PMA_SEL_ATTR, A_EN | A_LOCK | A_NONIDEM, 1'b1);
    commit();
    do_lookup(0, 64'h4000_0010, mk(1'b1, 3, 3'b001));
    cfg_write(3, PMA_SEL_BASE, 64'h5000_0000, 1'b0);
    cfg_write(3, PMA_SEL_ATTR, 64'h0, 1'b0);
    commit();
    do_lookup(0, 64'h4000_0010, mk(1'b1, 3, 3'b001));
    do_lookup(1, 64'h5000_0000, miss());
    cfg_write(NR, PMA_SEL_BASE, 64'h0, 1'b0);
    apply_reset();
    do_lookup(0, 64'h1000_0800, miss());
    cfg_write(3, PMA_SEL_BASE, 64'h5000_0000, 1'b1);
  endtask

  task automatic test_reset_mid();
    rsp_ready_i[0]     = 1'b0;
    lk_valid_i[0]      = 1'b1;
    lk_addr_i[0 +: AW] = 64'h8000_0000;
    cfg_req_i          = 1'b1;
    cfg_idx_i          = '0;
    cfg_sel_i          = PMA_SEL_BASE;
    cfg_wdata_i        = 64'h1234;
    tick();
    mon_en = 1'b0;
    n_checks++;
    if ({rsp_valid_o[0], cfg_gnt_o} !== 2'b11)
      $display("FAIL mid_pending: got valid=%b gnt=%b required 1 1", rsp_valid_o[0], cfg_gnt_o);
    else
      n_pass++;
    rst_i         = 1'b1;
    lk_valid_i[0] = 1'b0;
    tick();
    rst_i     = 1'b0;
    cfg_req_i = 1'b0;
    n_checks++;
    if ({rsp_valid_o, cfg_gnt_o, cfg_err_o} !== 4'b0000)
      $display("FAIL mid_reset: got valid=%b gnt=%b err=%b required 00 0 0",
               rsp_valid_o, cfg_gnt_o, cfg_err_o);
    else
      n_pass++;
    rsp_ready_i = '1;
    for (int p = 0; p < NP; p++) held_v[p] = 1'b0;
    mon_en = 1'b1;
  endtask

  initial begin
    rst_i = 1'b1;
    test_reset();
    test_default_miss();
    test_overlap();
    test_back_to_back();
    test_top_range();
    test_shadow_commit();
    test_lock();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
